// File: rtl/moving_average_filter.sv
// Moving-average filter over a power-of-two sample window, with raw-sample bypass
// and a multi-cycle flush that zeroes the window history one entry per cycle.
module moving_average_filter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LOG2_DEPTH = 4,
  parameter bit          SIGNED     = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              bypass,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              window_full
);

  localparam int unsigned DEPTH = 2 ** LOG2_DEPTH;
  localparam int unsigned SUM_W = DATA_W + LOG2_DEPTH;

  localparam logic [LOG2_DEPTH:0]   FillLast  = (LOG2_DEPTH + 1)'(DEPTH - 1);
  localparam logic [LOG2_DEPTH-1:0] FlushLast = LOG2_DEPTH'(DEPTH - 1);

  typedef enum logic [1:0] {StFill, StRun, StFlush} state_e;

  state_e                state_q, state_d;
  logic [DATA_W-1:0]     window_q [DEPTH];
  logic [LOG2_DEPTH-1:0] ptr_q, ptr_d;
  logic [LOG2_DEPTH-1:0] flush_cnt_q, flush_cnt_d;
  logic [LOG2_DEPTH:0]   fill_q, fill_d;
  logic [SUM_W-1:0]      sum_q, sum_d;
  logic                  full_q, full_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_W-1:0]     out_data_q, out_data_d;

  logic [SUM_W-1:0]  in_ext, old_ext, sum_upd;
  logic [DATA_W-1:0] avg;
  logic              accept, fill_done;

  assign in_ready  = (state_q != StFlush) && !flush;
  assign accept    = in_valid && in_ready;
  assign fill_done = (state_q == StFill) && (fill_q == FillLast);

  assign in_ext  = {{LOG2_DEPTH{SIGNED & in_data[DATA_W-1]}}, in_data};
  assign old_ext = {{LOG2_DEPTH{SIGNED & window_q[ptr_q][DATA_W-1]}}, window_q[ptr_q]};
  assign sum_upd = sum_q - old_ext + in_ext;

  // After truncation to DATA_W, arithmetic and logical shifts agree: the kept
  // bits are exactly the upper DATA_W bits of the (sign-extended) sum.
  assign avg = sum_upd[SUM_W-1:LOG2_DEPTH];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    flush_cnt_d = flush_cnt_q;
    fill_d      = fill_q;
    sum_d       = sum_q;
    full_d      = full_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;

    if (accept) begin
      sum_d = sum_upd;
      ptr_d = ptr_q + 1'b1;
      if (bypass) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
      end else if (state_q == StRun || fill_done) begin
        out_valid_d = 1'b1;
        out_data_d  = avg;
      end
    end

    unique case (state_q)
      StFill: begin
        if (flush) begin
          state_d     = StFlush;
          flush_cnt_d = '0;
        end else if (accept) begin
          fill_d = fill_q + 1'b1;
          if (fill_done) begin
            state_d = StRun;
            full_d  = 1'b1;
          end
        end
      end
      StRun: begin
        if (flush) begin
          state_d     = StFlush;
          flush_cnt_d = '0;
        end
      end
      StFlush: begin
        flush_cnt_d = flush_cnt_q + 1'b1;
        if (flush_cnt_q == FlushLast) begin
          state_d = StFill;
          sum_d   = '0;
          ptr_d   = '0;
          fill_d  = '0;
          full_d  = 1'b0;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StFill;
      ptr_q       <= '0;
      flush_cnt_q <= '0;
      fill_q      <= '0;
      sum_q       <= '0;
      full_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      flush_cnt_q <= flush_cnt_d;
      fill_q      <= fill_d;
      sum_q       <= sum_d;
      full_q      <= full_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Window storage: flush zeroes one slot per cycle, otherwise accepted samples overwrite.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        window_q[i] <= '0;
      end
    end else if (state_q == StFlush) begin
      window_q[flush_cnt_q] <= '0;
    end else if (accept) begin
      window_q[ptr_q] <= in_data;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign window_full = full_q;

endmodule

// File: tb/tb_moving_average_filter.sv
// Scoreboard bench: drivers queue expected outputs, per-DUT monitors pop and compare
// on every out_valid. Covers unsigned 32-bit and signed 8-bit configurations.
module tb_moving_average_filter;

  logic clk, rst;

  logic        u_in_valid, u_in_ready, u_bypass, u_flush, u_out_valid, u_full;
  logic [31:0] u_in_data, u_out_data;
  logic        s_in_valid, s_in_ready, s_bypass, s_flush, s_out_valid, s_full;
  logic [7:0]  s_in_data, s_out_data;

  logic [31:0] q_u[$];
  logic [7:0]  q_s[$];
  logic [31:0] e_u;
  logic [7:0]  e_s;
  int n_tests = 0;
  int n_fail  = 0;

  moving_average_filter dut_u (
    .clk(clk), .rst(rst), .in_valid(u_in_valid), .in_data(u_in_data), .in_ready(u_in_ready),
    .bypass(u_bypass), .flush(u_flush), .out_valid(u_out_valid), .out_data(u_out_data),
    .window_full(u_full)
  );

  moving_average_filter #(.DATA_W(8), .LOG2_DEPTH(4), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready),
    .bypass(s_bypass), .flush(s_flush), .out_valid(s_out_valid), .out_data(s_out_data),
    .window_full(s_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (u_out_valid === 1'b1) begin
      if (q_u.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL u_unexpected_out: got out_valid with %0h expected no output", u_out_data);
      end else begin
        e_u = q_u.pop_front();
        check("u_out_data", {32'd0, u_out_data}, {32'd0, e_u});
      end
    end
    if (s_out_valid === 1'b1) begin
      if (q_s.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL s_unexpected_out: got out_valid with %0h expected no output", s_out_data);
      end else begin
        e_s = q_s.pop_front();
        check("s_out_data", {56'd0, s_out_data}, {56'd0, e_s});
      end
    end
  end

  task automatic send_u(input logic [31:0] d, input bit exp_out, input logic [31:0] ev);
    @(negedge clk);
    u_in_valid = 1'b1;
    u_in_data  = d;
    if (exp_out) q_u.push_back(ev);
  endtask

  task automatic send_s(input logic [7:0] d, input bit exp_out, input logic [7:0] ev);
    @(negedge clk);
    s_in_valid = 1'b1;
    s_in_data  = d;
    if (exp_out) q_s.push_back(ev);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      u_in_valid = 1'b0;
      s_in_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    u_in_valid = 1'b0; u_in_data = '0; u_bypass = 1'b0; u_flush = 1'b0;
    s_in_valid = 1'b0; s_in_data = '0; s_bypass = 1'b0; s_flush = 1'b0;
    #3;
    check("rst_out_valid", {63'd0, u_out_valid}, 64'd0);
    check("rst_out_data", {32'd0, u_out_data}, 64'd0);
    check("rst_window_full", {63'd0, u_full}, 64'd0);
    check("rst_in_ready", {63'd0, u_in_ready}, 64'd1);
    check("rst_s_out_valid", {63'd0, s_out_valid}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Signed 8-bit: 16 x -3 averages to -3; one 13 gives sum -32, average -2.
    for (int i = 0; i < 16; i++) send_s(8'hFD, i == 15, 8'hFD);
    send_s(8'd13, 1'b1, 8'hFE);
    idle(2);
    check("s_window_full", {63'd0, s_full}, 64'd1);

    // Bypass from reset.
    u_bypass = 1'b1;
    send_u(32'd5, 1'b1, 32'd5);
    send_u(32'd7, 1'b1, 32'd7);
    send_u(32'd9, 1'b1, 32'd9);
    idle(2);
    check("bypass_window_full", {63'd0, u_full}, 64'd0);
    u_bypass = 1'b0;
    do_reset();

    // Fill with 16 x 16, then one 32 -> (15*16+32)/16 = 17.
    for (int i = 0; i < 16; i++) send_u(32'd16, i == 15, 32'd16);
    idle(1);
    check("fill_window_full", {63'd0, u_full}, 64'd1);
    send_u(32'd32, 1'b1, 32'd17);
    idle(2);

    // Flush in RUN with a sample offered the same cycle; a second flush mid-FLUSH is ignored.
    @(negedge clk);
    u_flush = 1'b1;
    u_in_valid = 1'b1;
    u_in_data = 32'd1000;
    #1 check("flush_cycle_in_ready", {63'd0, u_in_ready}, 64'd0);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      u_in_valid = 1'b0;
      u_flush = (i == 5);
      #1 check("flushing_in_ready", {63'd0, u_in_ready}, 64'd0);
    end
    @(negedge clk);
    u_flush = 1'b0;
    #1 check("post_flush_in_ready", {63'd0, u_in_ready}, 64'd1);
    check("post_flush_window_full", {63'd0, u_full}, 64'd0);
    for (int i = 0; i < 16; i++) send_u(32'd48, i == 15, 32'd48);
    idle(2);
    check("refill_window_full", {63'd0, u_full}, 64'd1);
    do_reset();

    // All-ones stream, then asynchronous reset mid-run.
    for (int i = 0; i < 64; i++) send_u(32'hFFFF_FFFF, i >= 15, 32'hFFFF_FFFF);
    @(negedge clk);
    u_in_data = 32'hFFFF_FFFF;
    #3 rst = 1'b1;
    #1;
    check("midrun_rst_out_valid", {63'd0, u_out_valid}, 64'd0);
    check("midrun_rst_out_data", {32'd0, u_out_data}, 64'd0);
    check("midrun_rst_window_full", {63'd0, u_full}, 64'd0);
    check("midrun_rst_in_ready", {63'd0, u_in_ready}, 64'd1);
    idle(2);
    rst = 1'b0;
    idle(4);
    check("after_rst_window_full", {63'd0, u_full}, 64'd0);

    check("u_queue_drained", 64'(q_u.size()), 64'd0);
    check("s_queue_drained", 64'(q_s.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
